// File: rtl/bram_uart_dump_pkg.sv
// Shared types and constants for the BRAM-to-UART dump block.
// Holds the FSM state type, baud divisor function and ASCII codes.
package bram_uart_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        SEND,
        NEXT,
        FIN
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Rounded clocks-per-bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter with registered tx output.
// Ports: clk, reset_n, valid/data in, ready, tx, done_pulse.
import bram_uart_dump_pkg::*;

module uart_tx_byte #(
    parameter int DIV = 278
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       done_pulse
);

    localparam int BW = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    logic          active;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic [8:0]    shreg;
    logic          tx_r;
    logic          bit_end;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign done_pulse = active && bit_end && (bit_cnt == 4'd9);
    // Ready in the final stop cycle so frames chain back to back.
    assign ready      = !active || done_pulse;
    assign tx         = tx_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= '1;
            tx_r     <= 1'b1;
        end else if (valid && ready) begin
            active   <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= {1'b1, data};
            tx_r     <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx_r   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx_r    <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_uart_dump.sv
// Reads NWORDS words from darkram X port and sends them on UART tx.
// Ports: start/base_addr, X-port bus, tx, busy, done. BRAM_UART_DUMP_HEX_EN: hex text.
import bram_uart_dump_pkg::*;

module bram_uart_dump #(
    parameter int CLK_HZ     = 32000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 32,
    parameter int NWORDS     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  XDREQ,
    output logic                  XRD,
    output logic                  XWR,
    output logic [3:0]            XBE,
    output logic [ADDR_WIDTH-1:0] XADDR,
    input  logic [31:0]           XATAO,
    input  logic                  XDACK,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(NWORDS + 1);
`ifdef BRAM_UART_DUMP_HEX_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd3;
`endif

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] xaddr;
    logic [31:0]           word;
    logic [CW-1:0]         cnt;
    logic [3:0]            idx;
    logic [3:0]            cidx;
    logic                  sent;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_done;
    logic [7:0]            tx_data;
    logic                  last_word;

    assign XADDR     = xaddr;
    assign XDREQ     = (state == REQ);
    assign XRD       = (state == REQ);
    assign XWR       = 1'b0;
    assign XBE       = 4'hf;
    assign busy      = (state == REQ) || (state == LOAD) ||
                       (state == SEND) || (state == NEXT);
    assign done      = (state == FIN);
    assign last_word = (cnt == CW'(NWORDS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // While a byte is in flight, offer the following one so the
    // transmitter can take it in its final stop cycle.
    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        cidx     = sent ? idx + 4'd1 : idx;
        unique case (state)
            IDLE: if (start) state_n = REQ;
            REQ:  if (XDACK) state_n = LOAD;
            LOAD: state_n = SEND;
            SEND: begin
                tx_valid = !sent || (tx_done && idx != LAST_IDX);
                if (tx_done && idx == LAST_IDX) state_n = NEXT;
            end
            NEXT: state_n = last_word ? FIN : REQ;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
`ifdef BRAM_UART_DUMP_HEX_EN
        if (cidx == 4'd8) begin
            tx_data = ASCII_CR;
        end else if (cidx == 4'd9) begin
            tx_data = ASCII_LF;
        end else begin
            tx_data = hex_char(4'(word >> {3'd7 - cidx[2:0], 2'b00}));
        end
`else
        tx_data = 8'(word >> {cidx, 3'b000});
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xaddr <= '0;
            word  <= '0;
            cnt   <= '0;
            idx   <= '0;
            sent  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    xaddr <= base_addr & ~ADDR_WIDTH'(3);
                    cnt   <= '0;
                end
                REQ: if (XDACK) word <= XATAO;
                LOAD: begin
                    idx  <= '0;
                    sent <= 1'b0;
                end
                SEND: begin
                    if (tx_valid && tx_ready && !sent) sent <= 1'b1;
                    if (tx_done) begin
                        if (idx == LAST_IDX) sent <= 1'b0;
                        else idx <= idx + 4'd1;
                    end
                end
                NEXT: begin
                    xaddr <= xaddr + ADDR_WIDTH'(4);
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (tx_valid),
        .data       (tx_data),
        .ready      (tx_ready),
        .tx         (tx),
        .done_pulse (tx_done)
    );

endmodule

// File: tb/tb_bram_uart_dump.sv
// Scoreboard bench for bram_uart_dump: two instances (1 word at 278
// clk/bit, 4 words at 10 clk/bit) share stimulus and a UART monitor.
module tb_bram_uart_dump;

    localparam int DIV_A = 278;
    localparam int DIV_B = 10;
`ifdef BRAM_UART_DUMP_HEX_EN
    localparam int BPW = 10;
`else
    localparam int BPW = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;
    logic [31:0] base;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nrx = 0;
    int nd_a = 0;
    int nd_b = 0;
    string hexs = "0123456789ABCDEF";

    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];

    logic start_a, start_b;
    logic xdreq_a, xrd_a, xwr_a, xdack_a, tx_a, busy_a, done_a;
    logic xdreq_b, xrd_b, xwr_b, xdack_b, tx_b, busy_b, done_b;
    logic [3:0]  xbe_a, xbe_b;
    logic [31:0] xaddr_a, xaddr_b, xatao_a, xatao_b;
    logic [1:0]  lat_a = 2'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1234_5678;
            32'h0000_0004: return 32'h89AB_CDEF;
            32'h0000_0008: return 32'hDEAD_BEEF;
            32'h0000_000C: return 32'h0BAD_F00D;
            32'h0000_0010: return 32'hCAFE_BABE;
            32'h0000_0014: return 32'h0102_0304;
            32'hFFFF_FFFC: return 32'hA5A5_5A5A;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    // Port A acks two cycles after request; port B acks immediately.
    always @(posedge clk) lat_a <= (xdreq_a && !xdack_a) ? lat_a + 2'd1 : 2'd0;
    assign xdack_a = xdreq_a && (lat_a == 2'd2);
    assign xatao_a = mem(xaddr_a);
    assign xdack_b = xdreq_b;
    assign xatao_b = mem(xaddr_b);

    bram_uart_dump #(.NWORDS(1)) dut_a (
        .clk(clk), .reset_n(rst_n), .start(start_a), .base_addr(base),
        .XDREQ(xdreq_a), .XRD(xrd_a), .XWR(xwr_a), .XBE(xbe_a),
        .XADDR(xaddr_a), .XATAO(xatao_a), .XDACK(xdack_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    bram_uart_dump #(.CLK_HZ(1000000), .BAUD(100000), .NWORDS(4)) dut_b (
        .clk(clk), .reset_n(rst_n), .start(start_b), .base_addr(base),
        .XDREQ(xdreq_b), .XRD(xrd_b), .XWR(xwr_b), .XBE(xbe_b),
        .XADDR(xaddr_b), .XATAO(xatao_b), .XDACK(xdack_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    logic txm, busym, donem, xdreqm, xdackm, xrdm, xwrm;
    logic [3:0]  xbem;
    logic [31:0] xaddrm;
    assign txm    = sel ? tx_b : tx_a;
    assign busym  = sel ? busy_b : busy_a;
    assign donem  = sel ? done_b : done_a;
    assign xdreqm = sel ? xdreq_b : xdreq_a;
    assign xdackm = sel ? xdack_b : xdack_a;
    assign xrdm   = sel ? xrd_b : xrd_a;
    assign xwrm   = sel ? xwr_b : xwr_a;
    assign xbem   = sel ? xbe_b : xbe_a;
    assign xaddrm = sel ? xaddr_b : xaddr_a;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_a) nd_a++;
        if (done_b) nd_b++;
    end

    always @(negedge clk) begin
        if (rst_n && xdreqm && xdackm) begin
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xaddr_extra: got %h want none", xaddrm);
            end else begin
                check("xaddr", xaddrm, addr_q.pop_front());
            end
            check("xrd_xwr_xbe", {26'd0, xrdm, xwrm, xbem}, 32'h2f);
        end
    end

    // UART receiver: mid-bit sampling, frames hit by reset are dropped.
    initial begin : uart_mon
        int d;
        int t0;
        int prev_t0;
        logic [7:0] b;
        logic s0, s1, abort;
        prev_t0 = -1000000;
        forever begin
            @(negedge clk);
            if (rst_n && txm == 1'b0) begin
                d = sel ? DIV_B : DIV_A;
                t0 = cyc;
                abort = 1'b0;
                for (int k = 0; k < d / 2; k++) begin
                    @(negedge clk);
                    abort |= !rst_n;
                end
                s0 = txm;
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < d; k++) begin
                        @(negedge clk);
                        abort |= !rst_n;
                    end
                    b[i] = txm;
                end
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    abort |= !rst_n;
                end
                s1 = txm;
                if (!abort) begin
                    if (t0 - prev_t0 <= 10 * d + 2)
                        check("byte_spacing", t0 - prev_t0, 10 * d);
                    prev_t0 = t0;
                    nrx++;
                    check("framing", {30'd0, s0, s1}, 32'h1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_extra: got %h want none", b);
                    end else begin
                        check("tx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
`ifdef BRAM_UART_DUMP_HEX_EN
        for (int i = 7; i >= 0; i--) exp_q.push_back(hexs[w[4*i +: 4]]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
`endif
    endtask

    task automatic run_dump(input logic s, input logic [31:0] b,
                            input int nw, input logic poke,
                            output int lowb);
        logic [31:0] a;
        logic seen;
        int budget;
        sel = s;
        base = b;
        a = {b[31:2], 2'b00};
        for (int w = 0; w < nw; w++) begin
            addr_q.push_back(a);
            push_word(mem(a));
            a = a + 32'd4;
        end
        budget = nw * (BPW * 10 * (s ? DIV_B : DIV_A) + 100);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lowb = 0;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start = poke && (c == 30);
            if (donem) begin
                seen = 1'b1;
                break;
            end
            if (!busym) lowb++;
        end
        start = 1'b0;
        check("done_in_time", {31'd0, seen}, 32'd1);
        repeat (20) @(negedge clk);
    endtask

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lowb, nd0, n0;
        logic found;
        rst_n = 1'b0;
        start = 1'b1;
        sel = 1'b0;
        base = 32'h0;
        repeat (5) @(negedge clk);
        check("reset_a", {28'd0, tx_a, busy_a, xdreq_a, done_a}, 32'h8);
        check("reset_b", {28'd0, tx_b, busy_b, xdreq_b, done_b}, 32'h8);
        check("reset_xaddr_a", xaddr_a, 32'h0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_a", {29'd0, tx_a, busy_a, xdreq_a}, 32'h4);
        check("idle_b", {29'd0, tx_b, busy_b, xdreq_b}, 32'h4);
        check("no_done_after_reset", nd_a + nd_b, 0);

        nd0 = nd_a;
        n0 = nrx;
        run_dump(1'b0, 32'h0, 1, 1'b0, lowb);
        check("busy_low_a", lowb, 0);
        check("done_count_a", nd_a - nd0, 1);
        check("xaddr_end_a", xaddr_a, 32'h4);
        check("bytes_a", nrx - n0, BPW);

        nd0 = nd_b;
        n0 = nrx;
        run_dump(1'b1, 32'hB, 4, 1'b1, lowb);
        check("busy_low_b", lowb, 0);
        check("done_count_b", nd_b - nd0, 1);
        check("xaddr_end_b", xaddr_b, 32'h18);
        check("bytes_b", nrx - n0, 4 * BPW);

        nd0 = nd_b;
        run_dump(1'b1, 32'hFFFF_FFFC, 4, 1'b0, lowb);
        check("done_count_wrap", nd_b - nd0, 1);
        check("xaddr_end_wrap", xaddr_b, 32'hC);

        sel = 1'b0;
        base = 32'h14;
        addr_q.push_back(32'h14);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!tx_a) begin
                found = 1'b1;
                break;
            end
        end
        check("start_bit_seen", {31'd0, found}, 32'd1);
        repeat (4 * DIV_A + DIV_A / 2) @(negedge clk);
        check("tx_bit3_low", {31'd0, tx_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_byte", {29'd0, tx_a, busy_a, xdreq_a}, 32'h4);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * DIV_A) @(negedge clk);
        check("idle_after_abort", {29'd0, tx_a, busy_a, xdreq_a}, 32'h4);
        check("exp_q_empty", exp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
